csa_accumulator: RTL and testbench

Sequential multi-operand carry-save accumulator for the FPU FMAC datapath. It absorbs one operand per accepted beat into a redundant sum/carry pair, with no carry propagation in the loop. After the last operand of a group it performs a single carry-propagate add and presents the result through a valid/ready handshake. Per-operand subtraction is supported by injecting the two's-complement +1 into the free carry LSB.

---
 rtl/csa_accumulator_if.sv | 40 ++++
 rtl/csa_accumulator.sv | 104 ++++++++++
 tb/tb_csa_accumulator.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/csa_accumulator_if.sv
// Operand-in / result-out handshake bundle for the carry-save accumulator.
// The master drives operands and Out_Ready_SI; the slave (the accumulator) drives everything else.
interface csa_accumulator_if #(
    parameter int unsigned WIDTH = 49,
    parameter int unsigned CNT_W = 8
);
    logic             In_Valid_SI;
    logic             In_Ready_SO;
    logic [WIDTH-1:0] Operand_DI;
    logic             Sub_SI;
    logic             Last_SI;
    logic             Out_Valid_SO;
    logic             Out_Ready_SI;
    logic [WIDTH-1:0] Result_DO;
    logic [CNT_W-1:0] Count_DO;

    modport master (
        output In_Valid_SI,
        input  In_Ready_SO,
        output Operand_DI,
        output Sub_SI,
        output Last_SI,
        input  Out_Valid_SO,
        output Out_Ready_SI,
        input  Result_DO,
        input  Count_DO
    );

    modport slave (
        input  In_Valid_SI,
        output In_Ready_SO,
        input  Operand_DI,
        input  Sub_SI,
        input  Last_SI,
        output Out_Valid_SO,
        input  Out_Ready_SI,
        output Result_DO,
        output Count_DO
    );
endinterface

// File: rtl/csa_accumulator.sv
// Sequential carry-save accumulator: one operand per beat into a redundant S/C pair,
// then a single carry-propagate add whose result is offered on a valid/ready handshake.
module csa_accumulator #(
    parameter int unsigned WIDTH = 49,
    parameter int unsigned CNT_W = 8
) (
    input  logic          Clk_CI,
    input  logic          Rst_RBI,
    input  logic          Flush_SI,
    csa_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        StAcc  = 2'd0,
        StAdd  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] maj;
    logic             in_ready;
    logic             out_valid;

    // Subtraction: invert here, the +1 rides in the carry LSB freed by the shift.
    assign x   = bus.Sub_SI ? ~bus.Operand_DI : bus.Operand_DI;
    assign maj = (s_q & c_q) | (s_q & x) | (c_q & x);

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        c_d       = c_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            StAcc: begin
                in_ready = 1'b1;
                if (bus.In_Valid_SI) begin
                    s_d = s_q ^ c_q ^ x;
                    c_d = {maj[WIDTH-2:0], bus.Sub_SI};
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (bus.Last_SI) begin
                        state_d = StAdd;
                    end
                end
            end
            StAdd: begin
                res_d   = s_q + c_q;
                state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (bus.Out_Ready_SI) begin
                    s_d     = '0;
                    c_d     = '0;
                    cnt_d   = '0;
                    state_d = StAcc;
                end
            end
            default: begin
                state_d = StAcc;
            end
        endcase

        // Flush overrides any accept or handshake in the same cycle; the result is kept.
        if (Flush_SI) begin
            s_d     = '0;
            c_d     = '0;
            cnt_d   = '0;
            state_d = StAcc;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            state_q <= StAcc;
            s_q     <= '0;
            c_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.In_Ready_SO  = in_ready;
    assign bus.Out_Valid_SO = out_valid;
    assign bus.Result_DO    = res_q;
    assign bus.Count_DO     = cnt_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Self-checking bench for csa_accumulator (WIDTH=8, CNT_W=4) against a plain modular-sum model.
module tb_csa_accumulator;

    localparam int unsigned W = 8;
    localparam int unsigned CW = 4;
    localparam int MOD = 256;
    localparam int CNT_MAX = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    csa_accumulator_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    csa_accumulator #(.WIDTH(W), .CNT_W(CW)) dut (
        .Clk_CI   (clk),
        .Rst_RBI  (rst_n),
        .Flush_SI (flush),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int exp_sum = 0;
    int exp_cnt = 0;
    int exp_res = 0;

    function automatic void model_accept(input int op, input bit sub);
        exp_sum = (exp_sum + (sub ? (MOD - op) : op)) % MOD;
        exp_cnt = (exp_cnt < CNT_MAX) ? exp_cnt + 1 : CNT_MAX;
    endfunction

    function automatic void model_clear();
        exp_sum = 0;
        exp_cnt = 0;
    endfunction

    task automatic idle_inputs();
        bus.In_Valid_SI  = 1'b0;
        bus.Operand_DI   = '0;
        bus.Sub_SI       = 1'b0;
        bus.Last_SI      = 1'b0;
        bus.Out_Ready_SI = 1'b0;
    endtask

    task automatic beat(input int op, input bit sub, input bit last);
        bus.In_Valid_SI = 1'b1;
        bus.Operand_DI  = W'(op);
        bus.Sub_SI      = sub;
        bus.Last_SI     = last;
        total++;
        if (bus.In_Ready_SO !== 1'b1)
            $display("FAIL beat_ready: got %0b want 1", bus.In_Ready_SO);
        @(posedge clk);
        #1;
        model_accept(op, sub);
        bus.In_Valid_SI = 1'b0;
        bus.Sub_SI      = 1'b0;
        bus.Last_SI     = 1'b0;
        total++;
        if (bus.Count_DO !== CW'(exp_cnt)) begin
            bad++;
            $display("FAIL beat_count: got %0d want %0d", bus.Count_DO, exp_cnt);
        end
    endtask

    // Call right after the Last beat; checks latency, result, backpressure hold and handshake.
    task automatic collect(input string name, input int hold, input bit junk);
        int n = 0;
        total++;
        if (bus.Out_Valid_SO !== 1'b0 || bus.In_Ready_SO !== 1'b0) begin
            bad++;
            $display("FAIL %s_add_state: valid=%0b ready=%0b want 0 0", name,
                     bus.Out_Valid_SO, bus.In_Ready_SO);
        end
        while (bus.Out_Valid_SO !== 1'b1 && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        exp_res = exp_sum;
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL %s_latency: got %0d cycles want 1 after ADD", name, n);
        end
        total++;
        if (bus.Result_DO !== W'(exp_res) || bus.Count_DO !== CW'(exp_cnt)) begin
            bad++;
            $display("FAIL %s_result: got res=%0d cnt=%0d want res=%0d cnt=%0d", name,
                     bus.Result_DO, bus.Count_DO, exp_res, exp_cnt);
        end
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                bus.In_Valid_SI = 1'b1;
                bus.Operand_DI  = W'($urandom);
                bus.Sub_SI      = 1'($urandom);
                bus.Last_SI     = 1'($urandom);
            end
            @(posedge clk);
            #1;
            total++;
            if (bus.Out_Valid_SO !== 1'b1 || bus.In_Ready_SO !== 1'b0 ||
                bus.Result_DO !== W'(exp_res) || bus.Count_DO !== CW'(exp_cnt)) begin
                bad++;
                $display("FAIL %s_hold: got v=%0b r=%0b res=%0d cnt=%0d want 1 0 %0d %0d",
                         name, bus.Out_Valid_SO, bus.In_Ready_SO, bus.Result_DO,
                         bus.Count_DO, exp_res, exp_cnt);
            end
        end
        bus.Out_Ready_SI = 1'b1;
        @(posedge clk);
        #1;
        bus.Out_Ready_SI = 1'b0;
        bus.In_Valid_SI  = 1'b0;
        bus.Sub_SI       = 1'b0;
        bus.Last_SI      = 1'b0;
        model_clear();
        total++;
        if (bus.Out_Valid_SO !== 1'b0 || bus.In_Ready_SO !== 1'b1 || bus.Count_DO !== '0) begin
            bad++;
            $display("FAIL %s_release: got v=%0b r=%0b cnt=%0d want 0 1 0", name,
                     bus.Out_Valid_SO, bus.In_Ready_SO, bus.Count_DO);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if (bus.Out_Valid_SO !== 1'b0 || bus.In_Ready_SO !== 1'b1 ||
            bus.Result_DO !== '0 || bus.Count_DO !== '0) begin
            bad++;
            $display("FAIL %s: got v=%0b r=%0b res=%0d cnt=%0d want 0 1 0 0", name,
                     bus.Out_Valid_SO, bus.In_Ready_SO, bus.Result_DO, bus.Count_DO);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
        exp_res = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        apply_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        beat(5, 0, 0);
        beat(7, 0, 0);
        beat(9, 0, 1);
        collect("add_5_7_9", 0, 0);
    endtask

    task automatic test_sub();
        beat(10, 0, 0);
        beat(3, 1, 1);
        collect("sub_10_3", 0, 0);
        beat(1, 1, 1);
        collect("neg_one", 0, 0);
    endtask

    task automatic test_wrap_saturate();
        beat(200, 0, 0);
        beat(100, 0, 1);
        collect("wrap", 0, 0);
        for (int i = 0; i < 17; i++) beat(255, 0, i == 16);
        collect("saturate", 0, 0);
    endtask

    task automatic test_backpressure();
        beat(77, 0, 0);
        beat(12, 1, 1);
        collect("backpressure", 5, 1);
        beat(4, 0, 1);
        collect("after_bp", 0, 0);
    endtask

    task automatic do_flush(input bit with_beat, input int op);
        bus.In_Valid_SI = with_beat;
        bus.Operand_DI  = W'(op);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.In_Valid_SI = 1'b0;
        model_clear();
        total++;
        if (bus.Count_DO !== '0 || bus.Out_Valid_SO !== 1'b0 || bus.Result_DO !== W'(exp_res)) begin
            bad++;
            $display("FAIL flush_state: got cnt=%0d v=%0b res=%0d want 0 0 %0d",
                     bus.Count_DO, bus.Out_Valid_SO, bus.Result_DO, exp_res);
        end
    endtask

    task automatic test_flush();
        beat(50, 0, 0);
        beat(60, 0, 0);
        do_flush(0, 0);
        beat(4, 0, 1);
        collect("flush_then_4", 0, 0);
        beat(3, 0, 0);
        do_flush(1, 9);
        beat(2, 0, 1);
        collect("flush_with_beat", 0, 0);
        // Flush while the result is waiting: valid drops, result is kept.
        beat(33, 0, 1);
        @(posedge clk);
        #1;
        exp_res = exp_sum;
        do_flush(0, 0);
        beat(6, 0, 1);
        collect("flush_in_done", 0, 0);
    endtask

    task automatic test_reset_mid();
        beat(8, 0, 1);
        apply_reset();
        check_reset_outputs("reset_in_add");
        rst_n = 1'b1;
        beat(20, 0, 1);
        @(posedge clk);
        #1;
        apply_reset();
        check_reset_outputs("reset_in_done");
        rst_n = 1'b1;
        beat(1, 0, 0);
        beat(2, 0, 1);
        collect("after_reset", 0, 0);
    endtask

    task automatic test_random();
        for (int g = 0; g < 40; g++) begin
            int len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                int gap = $urandom_range(0, 2);
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
                beat($urandom_range(0, 255), 1'($urandom), i == len - 1);
            end
            collect("random", $urandom_range(0, 3), 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sub();
        test_wrap_saturate();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
